mult_shift_add_seq: RTL



---
 rtl/mult_shift_add_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mult_shift_add_seq.sv
// ---------------------------------------------------------------------------
// mult_shift_add_seq
//
// Sequential unsigned shift-and-add multiplier. An operand pair is taken in
// through a valid/ready handshake. One partial-product row (multiplicand
// AND the current multiplier bit) is then added per clock into a
// 2*WIDTH-bit accumulator. The finished product is offered through a
// valid/ready output handshake. This is the iterative, small-footprint
// alternative to a fully parallel array multiplier.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair on in_a/in_b is valid
//   in_ready   block can accept an operand pair (IDLE)
//   in_a       unsigned multiplicand, WIDTH bits
//   in_b       unsigned multiplier,   WIDTH bits
//   out_valid  out_p holds a finished product (DONE)
//   out_ready  downstream accepts the product
//   out_p      unsigned product in_a*in_b, 2*WIDTH bits
//   busy       high while in RUN or DONE
//
// Latency is always WIDTH RUN cycles; there is no early exit on a zero
// multiplier. All outputs are decoded from state or taken straight from
// registers, so nothing combinational runs from in_valid/out_ready to an
// output.
// ---------------------------------------------------------------------------
module mult_shift_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [PW-1:0]    w_row;

  // The operand transfer happens only in IDLE; in_valid is a don't-care
  // everywhere else, so changes during RUN/DONE cannot disturb the result.
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_LAST);

  // Current partial-product row: the shifted multiplicand gated by the
  // multiplier bit that has been shifted down into position 0.
  assign w_row = r_mplr[0] ? r_mcand : '0;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // The final row is added on this same edge, so DONE already sees
        // the complete product.
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_mcand <= {{WIDTH{1'b0}}, in_a};
      r_mplr  <= in_b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      // (2^W-1)^2 < 2^(2W): this sum never carries out of the accumulator.
      r_acc   <= r_acc + w_row;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // The accumulator is the product register; it keeps its last value in
  // IDLE rather than being forced to zero.
  assign out_p = r_acc;

endmodule
